// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg: shared widths, body-word packing and scanner state encoding.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package snake_pkg;

  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int ADDR_W = 11;
  localparam int POS_W  = X_W + Y_W;

  localparam int DEF_X = 60;
  localparam int DEF_Y = 60;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } scan_state_e;

  // Body words are {x, y} with x in the upper bits.
  function automatic logic [POS_W-1:0] pack_pos(input logic [X_W-1:0] x,
                                                input logic [Y_W-1:0] y);
    return {x, y};
  endfunction

endpackage

`default_nettype wire

// File: rtl/snake_body_scanner.sv
// ---------------------------------------------------------------------------
// snake_body_scanner: walks the body RAM, streams segments and flags the
// lowest segment equal to a latched query point. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module snake_body_scanner
  import snake_pkg::*;
#(
  parameter int ADDR_W      = snake_pkg::ADDR_W,
  parameter int X_W         = snake_pkg::X_W,
  parameter int Y_W         = snake_pkg::Y_W,
  parameter int STOP_ON_HIT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    length_i,
  input  logic                 skip_first_i,
  input  logic [X_W-1:0]       query_x_i,
  input  logic [Y_W-1:0]       query_y_i,
  output logic [ADDR_W-1:0]    ram_address_o,
  input  logic [X_W+Y_W-1:0]   ram_q_i,
  output logic                 seg_valid_o,
  input  logic                 seg_ready_i,
  output logic [X_W-1:0]       seg_x_o,
  output logic [Y_W-1:0]       seg_y_o,
  output logic [ADDR_W-1:0]    seg_index_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 hit_o,
  output logic [ADDR_W-1:0]    hit_index_o
);

  scan_state_e             state_q;
  logic [ADDR_W-1:0]       ram_address_q;
  logic [ADDR_W-1:0]       length_q;
  logic [X_W-1:0]          query_x_q;
  logic [Y_W-1:0]          query_y_q;
  logic                    skip_q;
  logic                    seg_valid_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    hit_q;
  logic [ADDR_W-1:0]       hit_index_q;

  logic [ADDR_W-1:0]       ram_address_d;
  logic                    match;
  logic                    last_seg;
  logic                    stop_now;

  assign ram_address_d = ram_address_q + ADDR_W'(1);
  assign match    = (ram_q_i == {query_x_q, query_y_q}) &&
                    !(skip_q && (ram_address_q == '0));
  assign last_seg = (ram_address_q == (length_q - ADDR_W'(1)));
  assign stop_now = last_seg || ((STOP_ON_HIT != 0) && match);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ram_address_q <= '0;
      length_q      <= '0;
      query_x_q     <= '0;
      query_y_q     <= '0;
      skip_q        <= 1'b0;
      seg_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      hit_q         <= 1'b0;
      hit_index_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            length_q      <= length_i;
            query_x_q     <= query_x_i;
            query_y_q     <= query_y_i;
            skip_q        <= skip_first_i;
            hit_q         <= 1'b0;
            hit_index_q   <= '0;
            ram_address_q <= '0;
            busy_q        <= 1'b1;
            if (length_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          seg_valid_q <= 1'b1;
          state_q     <= S_EMIT;
        end
        S_EMIT: begin
          // Address is frozen until the handshake, keeping ram_q stable.
          if (seg_ready_i) begin
            seg_valid_q <= 1'b0;
            if (match && !hit_q) begin
              hit_q       <= 1'b1;
              hit_index_q <= ram_address_q;
            end
            if (stop_now) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              ram_address_q <= ram_address_d;
              state_q       <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_address_o = ram_address_q;
  assign seg_valid_o   = seg_valid_q;
  assign seg_x_o       = ram_q_i[X_W+Y_W-1:Y_W];
  assign seg_y_o       = ram_q_i[Y_W-1:0];
  assign seg_index_o   = ram_address_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign hit_o         = hit_q;
  assign hit_index_o   = hit_index_q;

endmodule

`default_nettype wire

// File: tb/tb_snake_body_scanner.sv
// ---------------------------------------------------------------------------
// tb_snake_body_scanner: scoreboard bench for two scanner builds
// (run-to-end and stop-on-hit) sharing one stimulus stream. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_snake_body_scanner;

  typedef struct packed {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [10:0] idx;
  } seg_t;

  typedef struct packed {
    logic        hit;
    logic [10:0] hidx;
    logic [31:0] done_e;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] length;
  logic        skip;
  logic [7:0]  qx;
  logic [6:0]  qy;
  logic        seg_ready;

  logic [10:0] addr_a, addr_b, sidx_a, sidx_b, hidx_a, hidx_b;
  logic [14:0] ram_q_a, ram_q_b;
  logic        sv_a, sv_b, busy_a, busy_b, done_a, done_b, hit_a, hit_b;
  logic [7:0]  sx_a, sx_b;
  logic [6:0]  sy_a, sy_b;

  logic [14:0] mem [0:2047];
  int          e = 0;
  int          total = 0;
  int          bad = 0;

  seg_t sq_a[$], sq_b[$];
  res_t rq_a[$], rq_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) e <= e + 1;

  always @(posedge clk) begin
    ram_q_a <= mem[addr_a];
    ram_q_b <= mem[addr_b];
  end

  snake_body_scanner #(.STOP_ON_HIT(0)) dut_a (
    .clk(clk), .rst(rst), .start_i(start), .length_i(length),
    .skip_first_i(skip), .query_x_i(qx), .query_y_i(qy),
    .ram_address_o(addr_a), .ram_q_i(ram_q_a), .seg_valid_o(sv_a),
    .seg_ready_i(seg_ready), .seg_x_o(sx_a), .seg_y_o(sy_a),
    .seg_index_o(sidx_a), .busy_o(busy_a), .done_o(done_a),
    .hit_o(hit_a), .hit_index_o(hidx_a)
  );

  snake_body_scanner #(.STOP_ON_HIT(1)) dut_b (
    .clk(clk), .rst(rst), .start_i(start), .length_i(length),
    .skip_first_i(skip), .query_x_i(qx), .query_y_i(qy),
    .ram_address_o(addr_b), .ram_q_i(ram_q_b), .seg_valid_o(sv_b),
    .seg_ready_i(seg_ready), .seg_x_o(sx_b), .seg_y_o(sy_b),
    .seg_index_o(sidx_b), .busy_o(busy_b), .done_o(done_b),
    .hit_o(hit_b), .hit_index_o(hidx_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
    end
  endtask

  // Monitor for the run-to-end build.
  always begin : mon_a
    seg_t s;
    res_t r;
    @(negedge clk);
    #1;
    if (!rst) begin
      if (sv_a && seg_ready) begin
        if (sq_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_seg: got index %0d expected no segment", sidx_a);
        end else begin
          s = sq_a.pop_front();
          chk("a_seg_x", 32'(sx_a), 32'(s.x));
          chk("a_seg_y", 32'(sy_a), 32'(s.y));
          chk("a_seg_index", 32'(sidx_a), 32'(s.idx));
        end
      end
      if (done_a) begin
        if (rq_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_done: got done=1 expected 0");
        end else begin
          r = rq_a.pop_front();
          chk("a_hit", 32'(hit_a), 32'(r.hit));
          chk("a_hit_index", 32'(hidx_a), 32'(r.hidx));
          chk("a_done_edge", 32'(e), r.done_e);
          chk("a_busy_at_done", 32'(busy_a), 32'd1);
        end
      end
    end
  end

  // Monitor for the stop-on-hit build.
  always begin : mon_b
    seg_t s;
    res_t r;
    @(negedge clk);
    #1;
    if (!rst) begin
      if (sv_b && seg_ready) begin
        if (sq_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_seg: got index %0d expected no segment", sidx_b);
        end else begin
          s = sq_b.pop_front();
          chk("b_seg_x", 32'(sx_b), 32'(s.x));
          chk("b_seg_y", 32'(sy_b), 32'(s.y));
          chk("b_seg_index", 32'(sidx_b), 32'(s.idx));
        end
      end
      if (done_b) begin
        if (rq_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_done: got done=1 expected 0");
        end else begin
          r = rq_b.pop_front();
          chk("b_hit", 32'(hit_b), 32'(r.hit));
          chk("b_hit_index", 32'(hidx_b), 32'(r.hidx));
          chk("b_done_edge", 32'(e), r.done_e);
          chk("b_busy_at_done", 32'(busy_b), 32'd1);
        end
      end
    end
  end

  // mode: 0 plain, 1 second start while busy, 2 three-cycle stall on segment 2
  task automatic scan(input logic [10:0] len, input logic [7:0] x, input logic [6:0] y,
                      input logic sk, input int mode,
                      input int na, input logic ha, input logic [10:0] ia, input int da,
                      input int nb, input logic hb, input logic [10:0] ib, input int db);
    int  k;
    bit  drained;
    @(negedge clk);
    start = 1'b1; length = len; qx = x; qy = y; skip = sk;
    k = e + 1;
    for (int i = 0; i < na; i++) sq_a.push_back({mem[i][14:7], mem[i][6:0], 11'(i)});
    for (int i = 0; i < nb; i++) sq_b.push_back({mem[i][14:7], mem[i][6:0], 11'(i)});
    rq_a.push_back({ha, ia, 32'(k + da)});
    rq_b.push_back({hb, ib, 32'(k + db)});
    @(negedge clk);
    start = 1'b0;
    drained = 1'b0;
    for (int n = 0; n < 100 && !drained; n++) begin
      @(negedge clk);
      if (mode == 1 && e == k + 3) begin
        start = 1'b1; length = 11'd1; qx = 8'd60; qy = 7'd60; skip = 1'b0;
      end else if (mode == 1 && e == k + 4) begin
        start = 1'b0;
      end
      if (mode == 2 && e >= k + 6 && e <= k + 8) begin
        chk("stall_valid", 32'(sv_a), 32'd1);
        chk("stall_x", 32'(sx_a), 32'd60);
        chk("stall_y", 32'(sy_a), 32'd62);
        chk("stall_addr", 32'(addr_a), 32'd2);
      end
      if (mode == 2 && e == k + 5) seg_ready = 1'b0;
      if (mode == 2 && e == k + 8) seg_ready = 1'b1;
      drained = (sq_a.size() == 0) && (sq_b.size() == 0) &&
                (rq_a.size() == 0) && (rq_b.size() == 0);
    end
    if (!drained) begin
      total++; bad++;
      $display("FAIL scan_timeout: got pending a=%0d/%0d b=%0d/%0d expected 0",
               sq_a.size(), rq_a.size(), sq_b.size(), rq_b.size());
      sq_a.delete(); sq_b.delete(); rq_a.delete(); rq_b.delete();
    end
    repeat (2) @(negedge clk);
    chk("a_hit_held", 32'(hit_a), 32'(ha));
    chk("a_idle_busy", 32'(busy_a), 32'd0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 2048; i++) mem[i] = 15'h0;
    mem[0] = {8'd60, 7'd60};
    mem[1] = {8'd60, 7'd61};
    mem[2] = {8'd60, 7'd62};
    mem[3] = {8'd60, 7'd63};
    mem[4] = {8'd10, 7'd10};
    rst = 1'b1; start = 1'b0; length = '0; skip = 1'b0;
    qx = '0; qy = '0; seg_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_valid", 32'(sv_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_hit", 32'(hit_a), 32'd0);
    chk("rst_hit_index", 32'(hidx_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    //    len    x      y     sk  mode  na hit idx  done  nb hit idx  done
    scan(11'd4, 8'd60, 7'd62, 0, 0,    4, 1, 11'd2, 8,   3, 1, 11'd2, 6);
    scan(11'd4, 8'd10, 7'd10, 0, 1,    4, 0, 11'd0, 8,   4, 0, 11'd0, 8);
    scan(11'd4, 8'd60, 7'd60, 1, 0,    4, 0, 11'd0, 8,   4, 0, 11'd0, 8);
    scan(11'd4, 8'd60, 7'd60, 0, 0,    4, 1, 11'd0, 8,   1, 1, 11'd0, 2);
    scan(11'd4, 8'd60, 7'd61, 0, 0,    4, 1, 11'd1, 8,   2, 1, 11'd1, 4);
    scan(11'd4, 8'd10, 7'd10, 0, 2,    4, 0, 11'd0, 11,  4, 0, 11'd0, 11);
    scan(11'd0, 8'd60, 7'd60, 0, 0,    0, 0, 11'd0, 0,   0, 0, 11'd0, 0);

    // Reset while segment 1 is on the stream: scan abandoned, no done.
    @(negedge clk);
    start = 1'b1; length = 11'd4; qx = 8'd60; qy = 7'd61; skip = 1'b0;
    k = e + 1;
    sq_a.push_back({8'd60, 7'd60, 11'd0});
    sq_b.push_back({8'd60, 7'd60, 11'd0});
    @(negedge clk);
    start = 1'b0;
    while (e < k + 3) @(negedge clk);
    chk("pre_rst_valid", 32'(sv_a), 32'd1);
    chk("pre_rst_index", 32'(sidx_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_addr", 32'(addr_a), 32'd0);
    chk("mid_rst_valid", 32'(sv_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_done", 32'(done_a), 32'd0);
    chk("mid_rst_hit", 32'(hit_a), 32'd0);
    chk("mid_rst_hit_index", 32'(hidx_a), 32'd0);
    chk("mid_rst_b_busy", 32'(busy_b), 32'd0);
    chk("mid_rst_b_valid", 32'(sv_b), 32'd0);
    repeat (12) @(negedge clk);
    chk("post_rst_seg_pending_a", 32'(sq_a.size()), 32'd0);
    chk("post_rst_seg_pending_b", 32'(sq_b.size()), 32'd0);
    chk("post_rst_idle_busy", 32'(busy_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
